ascon_din_feeder: RTL and testbench
===================================

// Module: ascon_din_feeder
// PURPOSE
// Input stage directly upstream of the Ascon control FSM. Derives block counts and pad indices
// from byte sizes, and packs a 32-bit word stream into 64-bit rate blocks (AD blocks first, then DI blocks).
// Drives the FSM's data_valid, ad_last and di_last inputs and its size/block/pad inputs.
// Owns the AD/DI block counters that the FSM loads and increments.
// PARAMETERS
// SIZE_WIDTH  16  byte-size width of AD and DI lengths
// BLOCK_AW    13  block-count width; must equal SIZE_WIDTH-3 (64-bit rate = 8 bytes)
// PORTS
// clk           in   1           clock
// rst_n         in   1           async active-low reset
// idle_i        in   1           FSM idle; synchronous abort/clear of the feeder
// ad_size_i     in   SIZE_WIDTH  AD length in bytes (sampled on load_cnt_i)
// di_size_i     in   SIZE_WIDTH  DI length in bytes (sampled on load_cnt_i)
// load_cnt_i    in   1           FSM load_ad_cnt/load_di_cnt (tied, asserted together)
// en_ad_cnt_i   in   1           FSM increments AD block counter
// en_di_cnt_i   in   1           FSM increments DI block counter
// pop_i         in   1           FSM en_buf_in: block consumed when pop_i && data_valid_o
// wdata_i       in   32          input word, first word of block -> block_o[63:32]
// wvalid_i      in   1           input word valid
// wready_o      out  1           input word accepted when wvalid_i && wready_o
// block_o       out  64          packed block; unused bytes zero
// data_valid_o  out  1           full (or last-partial) block ready
// ad_blk_no_o / di_blk_no_o    out  BLOCK_AW  size>>3 (number of full 8-byte blocks)
// ad_pad_idx_o / di_pad_idx_o  out  BLOCK_AW  size[2:0], zero-extended
// ad_last_o / di_last_o        out  1         ad_cnt_q==ad_blk_no_o / di_cnt_q==di_blk_no_o
// BEHAVIOUR
// - Reset: all registers 0; block_o=0, data_valid_o=0, wready_o=0, last flags=(0==0)=1, FSM Idle.
// - load_cnt_i: register sizes, clear ad_cnt_q/di_cnt_q, packer EMPTY, FSM -> first nonempty segment.
//   Order: AdFull (ad_blk_no>0), AdPart (ad_pad!=0), DiFull, DiPart, Done.
// - Counters: +1 on en_*_cnt_i; no wrap check (FSM never exceeds blk_no).
// - Segment FSM: Idle, AdFull, AdPart, DiFull, DiPart, Done. An internal produced-block counter
//   resets per segment; on pop: Full segment advances when produced==blk_no-1, Part after 1 pop.
//   Skip rule on every advance: go to next segment with nonzero length.
// - Words per block: Full=2; Part=1 if pad<=4 else 2. Packer: word cnt 0..2.
//   Block ready when cnt==need, so data_valid_o is registered-state based (no comb path from wvalid_i).
// - Partial block: bytes >= pad zeroed in block_o (byte 0 = block_o[63:56]). Padding is inserted by downstream.
// - wready_o = state in {Ad*,Di*} && cnt<need; 0 in Idle/Done. Accept and pop in same cycle not
//   possible (ready low when full). Pop clears packer next cycle; next word accepted 1 cycle after pop.
// - Latency: block with 2 words accepted cycles t,t+1 -> data_valid_o=1 at t+2.
// - idle_i=1 (abort/reset mid-op): next cycle FSM Idle, packer EMPTY, partial word dropped; has priority over load.
// - load_cnt_i while busy: restarts cleanly (same as after idle).
// - Simultaneous en_*_cnt_i and pop_i: both act; independent.
// - Empty AD and DI (both sizes 0): load -> Done, wready_o stays 0.
// STRUCTURE
// - Package ascon_pack: RateBytes=8, RateWords=2, feeder state typedef (feed_seg_e).
// - One sub-module: ascon_word_packer (32->64 packer with byte mask, cnt, need, pop, clear).
// - Top keeps size regs, block/pad derivation, counters, segment FSM.
// TESTING
// - AD=16,DI=8: load; words A0..A3,D0,D1 -> 3 blocks {A0,A1},{A2,A3},{D0,D1}; ad_blk_no=2, pad=0, Done.
// - AD=3: word 0xAABBCCDD -> block_o=0xAABBCC00_00000000, ad_pad_idx=3, blk_no=0, single pop.
// - AD=0,DI=13: first accepted word goes to DI. Block1 full; block2 needs 2 words;
//   bytes 5..7 zero; di_last_o=1 after 1 en_di_cnt.
// - Backpressure: block full, pop_i=0 for 10 cycles -> wready_o=0, block_o stable, data_valid_o held.
// - Abort: idle_i pulse after 1 word of 2 -> wready_o=0, data_valid_o=0; reload restarts at AD block 0.
// - Reset mid-block (rst_n low async) -> outputs at reset values immediately, no glitch on release.

Source files
------------

// File: rtl/ascon_din_feeder_pkg.sv
// Shared constants, segment state type and helper functions for the Ascon input feeder.
package ascon_din_feeder_pkg;

  localparam int RateBytes = 8;
  localparam int RateWords = 2;

  typedef enum logic [2:0] {
    SEG_IDLE    = 3'd0,
    SEG_AD_FULL = 3'd1,
    SEG_AD_PART = 3'd2,
    SEG_DI_FULL = 3'd3,
    SEG_DI_PART = 3'd4,
    SEG_DONE    = 3'd5
  } feed_seg_e;

  // First nonempty segment after cur, in the order AdFull, AdPart, DiFull, DiPart, Done.
  function automatic feed_seg_e next_seg(feed_seg_e cur, logic ad_full, logic ad_part,
                                         logic di_full, logic di_part);
    feed_seg_e n;
    n = SEG_DONE;
    case (cur)
      SEG_IDLE: begin
        if (ad_full)      n = SEG_AD_FULL;
        else if (ad_part) n = SEG_AD_PART;
        else if (di_full) n = SEG_DI_FULL;
        else if (di_part) n = SEG_DI_PART;
        else              n = SEG_DONE;
      end
      SEG_AD_FULL: begin
        if (ad_part)      n = SEG_AD_PART;
        else if (di_full) n = SEG_DI_FULL;
        else if (di_part) n = SEG_DI_PART;
        else              n = SEG_DONE;
      end
      SEG_AD_PART: begin
        if (di_full)      n = SEG_DI_FULL;
        else if (di_part) n = SEG_DI_PART;
        else              n = SEG_DONE;
      end
      SEG_DI_FULL: begin
        if (di_part)      n = SEG_DI_PART;
        else              n = SEG_DONE;
      end
      default: n = SEG_DONE;
    endcase
    return n;
  endfunction

  // Byte keep mask for one 32-bit word of a block; byte 0 of the block is the MSB of word 0.
  function automatic logic [31:0] word_mask(logic [2:0] pad, logic word_idx);
    logic [31:0] m;
    logic [2:0]  idx;
    m = 32'hFFFF_FFFF;
    for (int b = 0; b < 4; b++) begin
      idx = {word_idx, 2'(b)};
      if ((pad != 3'd0) && (idx >= pad)) begin
        m[31-8*b -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ascon_din_feeder_word_packer.sv
// Packs 32-bit words into a 64-bit rate block, zeroing bytes beyond the pad index.
module ascon_word_packer
  import ascon_din_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic [1:0]  need_i,
  input  logic [2:0]  pad_i,
  input  logic        pop_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [63:0] block_o,
  output logic        data_valid_o
);

  logic [1:0]  cnt_r;
  logic [31:0] w0_r;
  logic [31:0] w1_r;
  logic        accept_s;
  logic        pop_s;

  assign wready_o     = (cnt_r < need_i);
  assign data_valid_o = (need_i != 2'd0) && (cnt_r == need_i);
  assign accept_s     = wvalid_i && wready_o;
  assign pop_s        = pop_i && data_valid_o;
  assign block_o      = {w0_r, w1_r};

  // Word capture with masking applied at write time so block_o is purely registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 2'd0;
      w0_r  <= 32'd0;
      w1_r  <= 32'd0;
    end else if (clear_i || pop_s) begin
      cnt_r <= 2'd0;
      w0_r  <= 32'd0;
      w1_r  <= 32'd0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + 2'd1;
      if (cnt_r == 2'd0) begin
        w0_r <= wdata_i & word_mask(pad_i, 1'b0);
      end else begin
        w1_r <= wdata_i & word_mask(pad_i, 1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
      w0_r  <= w0_r;
      w1_r  <= w1_r;
    end
  end

endmodule

// File: rtl/ascon_din_feeder.sv
// Input stage ahead of the Ascon control FSM: size-derived block/pad info, block counters,
// and the AD-then-DI segment sequencer driving a 32->64 word packer.
module ascon_din_feeder
  import ascon_din_feeder_pkg::*;
#(
  parameter int SIZE_WIDTH = 16,
  parameter int BLOCK_AW   = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idle_i,
  input  logic [SIZE_WIDTH-1:0] ad_size_i,
  input  logic [SIZE_WIDTH-1:0] di_size_i,
  input  logic                  load_cnt_i,
  input  logic                  en_ad_cnt_i,
  input  logic                  en_di_cnt_i,
  input  logic                  pop_i,
  input  logic [31:0]           wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [63:0]           block_o,
  output logic                  data_valid_o,
  output logic [BLOCK_AW-1:0]   ad_blk_no_o,
  output logic [BLOCK_AW-1:0]   di_blk_no_o,
  output logic [BLOCK_AW-1:0]   ad_pad_idx_o,
  output logic [BLOCK_AW-1:0]   di_pad_idx_o,
  output logic                  ad_last_o,
  output logic                  di_last_o
);

  logic [SIZE_WIDTH-1:0] ad_size_r;
  logic [SIZE_WIDTH-1:0] di_size_r;
  logic [BLOCK_AW-1:0]   ad_cnt_r;
  logic [BLOCK_AW-1:0]   di_cnt_r;
  logic [BLOCK_AW-1:0]   prod_r;
  feed_seg_e             state_r;

  logic [1:0]            need_s;
  logic [2:0]            pad_s;
  logic [BLOCK_AW-1:0]   seg_blk_no_s;
  logic                  data_valid_s;
  logic                  pop_s;
  logic                  clear_s;
  logic                  ad_full_s, ad_part_s, di_full_s, di_part_s;
  logic                  ld_ad_full_s, ld_ad_part_s, ld_di_full_s, ld_di_part_s;

  assign ad_blk_no_o  = ad_size_r[SIZE_WIDTH-1:3];
  assign di_blk_no_o  = di_size_r[SIZE_WIDTH-1:3];
  assign ad_pad_idx_o = {{(BLOCK_AW-3){1'b0}}, ad_size_r[2:0]};
  assign di_pad_idx_o = {{(BLOCK_AW-3){1'b0}}, di_size_r[2:0]};
  assign ad_last_o    = (ad_cnt_r == ad_blk_no_o);
  assign di_last_o    = (di_cnt_r == di_blk_no_o);

  assign ad_full_s    = |ad_size_r[SIZE_WIDTH-1:3];
  assign ad_part_s    = |ad_size_r[2:0];
  assign di_full_s    = |di_size_r[SIZE_WIDTH-1:3];
  assign di_part_s    = |di_size_r[2:0];
  assign ld_ad_full_s = |ad_size_i[SIZE_WIDTH-1:3];
  assign ld_ad_part_s = |ad_size_i[2:0];
  assign ld_di_full_s = |di_size_i[SIZE_WIDTH-1:3];
  assign ld_di_part_s = |di_size_i[2:0];

  assign pop_s        = pop_i && data_valid_s;
  assign clear_s      = idle_i || load_cnt_i;
  assign data_valid_o = data_valid_s;

  // Words needed, byte pad and block count of the active segment.
  always_comb begin
    need_s       = 2'd0;
    pad_s        = 3'd0;
    seg_blk_no_s = ad_blk_no_o;
    case (state_r)
      SEG_AD_FULL: begin
        need_s = 2'd2;
      end
      SEG_AD_PART: begin
        pad_s  = ad_size_r[2:0];
        need_s = (ad_size_r[2:0] <= 3'd4) ? 2'd1 : 2'd2;
      end
      SEG_DI_FULL: begin
        need_s       = 2'd2;
        seg_blk_no_s = di_blk_no_o;
      end
      SEG_DI_PART: begin
        pad_s        = di_size_r[2:0];
        need_s       = (di_size_r[2:0] <= 3'd4) ? 2'd1 : 2'd2;
        seg_blk_no_s = di_blk_no_o;
      end
      default: begin
        need_s       = 2'd0;
        pad_s        = 3'd0;
        seg_blk_no_s = ad_blk_no_o;
      end
    endcase
  end

  // Size registers and FSM-owned block counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_size_r <= {SIZE_WIDTH{1'b0}};
      di_size_r <= {SIZE_WIDTH{1'b0}};
      ad_cnt_r  <= {BLOCK_AW{1'b0}};
      di_cnt_r  <= {BLOCK_AW{1'b0}};
    end else if (load_cnt_i) begin
      ad_size_r <= ad_size_i;
      di_size_r <= di_size_i;
      ad_cnt_r  <= {BLOCK_AW{1'b0}};
      di_cnt_r  <= {BLOCK_AW{1'b0}};
    end else begin
      ad_size_r <= ad_size_r;
      di_size_r <= di_size_r;
      ad_cnt_r  <= en_ad_cnt_i ? ad_cnt_r + {{(BLOCK_AW-1){1'b0}}, 1'b1} : ad_cnt_r;
      di_cnt_r  <= en_di_cnt_i ? di_cnt_r + {{(BLOCK_AW-1){1'b0}}, 1'b1} : di_cnt_r;
    end
  end

  // Segment sequencer; idle_i aborts with priority over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEG_IDLE;
      prod_r  <= {BLOCK_AW{1'b0}};
    end else if (idle_i) begin
      state_r <= SEG_IDLE;
      prod_r  <= {BLOCK_AW{1'b0}};
    end else if (load_cnt_i) begin
      state_r <= next_seg(SEG_IDLE, ld_ad_full_s, ld_ad_part_s, ld_di_full_s, ld_di_part_s);
      prod_r  <= {BLOCK_AW{1'b0}};
    end else if (pop_s) begin
      case (state_r)
        SEG_AD_FULL, SEG_DI_FULL: begin
          if (prod_r == seg_blk_no_s - {{(BLOCK_AW-1){1'b0}}, 1'b1}) begin
            state_r <= next_seg(state_r, ad_full_s, ad_part_s, di_full_s, di_part_s);
            prod_r  <= {BLOCK_AW{1'b0}};
          end else begin
            state_r <= state_r;
            prod_r  <= prod_r + {{(BLOCK_AW-1){1'b0}}, 1'b1};
          end
        end
        SEG_AD_PART, SEG_DI_PART: begin
          state_r <= next_seg(state_r, ad_full_s, ad_part_s, di_full_s, di_part_s);
          prod_r  <= {BLOCK_AW{1'b0}};
        end
        default: begin
          state_r <= state_r;
          prod_r  <= prod_r;
        end
      endcase
    end else begin
      state_r <= state_r;
      prod_r  <= prod_r;
    end
  end

  ascon_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_s),
    .need_i       (need_s),
    .pad_i        (pad_s),
    .pop_i        (pop_i),
    .wdata_i      (wdata_i),
    .wvalid_i     (wvalid_i),
    .wready_o     (wready_o),
    .block_o      (block_o),
    .data_valid_o (data_valid_s)
  );

endmodule

// File: tb/tb_ascon_din_feeder.sv
// Directed bench for ascon_din_feeder with hand-computed expected blocks and flags.
module tb_ascon_din_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idle_i = 1'b0;
  logic [15:0] ad_size_i = 16'd0;
  logic [15:0] di_size_i = 16'd0;
  logic        load_cnt_i = 1'b0;
  logic        en_ad_cnt_i = 1'b0;
  logic        en_di_cnt_i = 1'b0;
  logic        pop_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [63:0] block_o;
  logic        data_valid_o;
  logic [12:0] ad_blk_no_o, di_blk_no_o, ad_pad_idx_o, di_pad_idx_o;
  logic        ad_last_o, di_last_o;

  int checks = 0;
  int failures = 0;

  ascon_din_feeder #(.SIZE_WIDTH(16), .BLOCK_AW(13)) dut (
    .clk(clk), .rst_n(rst_n), .idle_i(idle_i), .ad_size_i(ad_size_i), .di_size_i(di_size_i),
    .load_cnt_i(load_cnt_i), .en_ad_cnt_i(en_ad_cnt_i), .en_di_cnt_i(en_di_cnt_i),
    .pop_i(pop_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .block_o(block_o), .data_valid_o(data_valid_o),
    .ad_blk_no_o(ad_blk_no_o), .di_blk_no_o(di_blk_no_o),
    .ad_pad_idx_o(ad_pad_idx_o), .di_pad_idx_o(di_pad_idx_o),
    .ad_last_o(ad_last_o), .di_last_o(di_last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] ad, input logic [15:0] di);
    ad_size_i  = ad;
    di_size_i  = di;
    load_cnt_i = 1'b1;
    step();
    load_cnt_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    while (!wready_o && n < 20) begin
      step();
      n++;
    end
    if (!wready_o) chk("push_timeout", {63'd0, wready_o}, 64'd1);
    wdata_i  = w;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
  endtask

  task automatic pop(input logic en_ad, input logic en_di);
    pop_i       = 1'b1;
    en_ad_cnt_i = en_ad;
    en_di_cnt_i = en_di;
    step();
    pop_i       = 1'b0;
    en_ad_cnt_i = 1'b0;
    en_di_cnt_i = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_block", block_o, 64'd0);
    chk("rst_dv", {63'd0, data_valid_o}, 64'd0);
    chk("rst_wready", {63'd0, wready_o}, 64'd0);
    chk("rst_lasts", {62'd0, ad_last_o, di_last_o}, 64'd3);
    step();
    rst_n = 1'b1;
    step();

    // AD=16, DI=8: three full blocks then Done
    load(16'd16, 16'd8);
    chk("s1_ad_blk_no", {51'd0, ad_blk_no_o}, 64'd2);
    chk("s1_ad_pad", {51'd0, ad_pad_idx_o}, 64'd0);
    chk("s1_di_blk_no", {51'd0, di_blk_no_o}, 64'd1);
    chk("s1_wready", {63'd0, wready_o}, 64'd1);
    push(32'hA0A0_0000);
    chk("s1_dv_one_word", {63'd0, data_valid_o}, 64'd0);
    push(32'hA1A1_1111);
    chk("s1_dv_b0", {63'd0, data_valid_o}, 64'd1);
    chk("s1_blk0", block_o, 64'hA0A0_0000_A1A1_1111);
    chk("s1_wready_full", {63'd0, wready_o}, 64'd0);
    pop(1'b1, 1'b0);
    chk("s1_dv_after_pop", {63'd0, data_valid_o}, 64'd0);
    chk("s1_ad_last_mid", {63'd0, ad_last_o}, 64'd0);
    push(32'hA2A2_2222);
    push(32'hA3A3_3333);
    chk("s1_blk1", block_o, 64'hA2A2_2222_A3A3_3333);
    pop(1'b1, 1'b0);
    chk("s1_ad_last", {63'd0, ad_last_o}, 64'd1);
    push(32'hD0D0_4444);
    push(32'hD1D1_5555);
    chk("s1_blk2", block_o, 64'hD0D0_4444_D1D1_5555);
    pop(1'b0, 1'b1);
    chk("s1_di_last", {63'd0, di_last_o}, 64'd1);
    step();
    chk("s1_done_wready", {63'd0, wready_o}, 64'd0);
    chk("s1_done_dv", {63'd0, data_valid_o}, 64'd0);

    // AD=3 partial: one word, bytes 3..7 zeroed
    load(16'd3, 16'd0);
    chk("s2_blk_no", {51'd0, ad_blk_no_o}, 64'd0);
    chk("s2_pad", {51'd0, ad_pad_idx_o}, 64'd3);
    push(32'hAABB_CCDD);
    chk("s2_dv", {63'd0, data_valid_o}, 64'd1);
    chk("s2_block", block_o, 64'hAABB_CC00_0000_0000);
    pop(1'b0, 1'b0);
    chk("s2_done_wready", {63'd0, wready_o}, 64'd0);

    // AD=0, DI=13: full DI block, then 2-word partial with bytes 5..7 zero
    load(16'd0, 16'd13);
    chk("s3_di_blk_no", {51'd0, di_blk_no_o}, 64'd1);
    chk("s3_di_pad", {51'd0, di_pad_idx_o}, 64'd5);
    push(32'h1122_3344);
    push(32'h5566_7788);
    chk("s3_blk0", block_o, 64'h1122_3344_5566_7788);
    pop(1'b0, 1'b1);
    chk("s3_di_last", {63'd0, di_last_o}, 64'd1);
    push(32'h99AA_BBCC);
    chk("s3_part_one_word", {63'd0, data_valid_o}, 64'd0);
    push(32'hDDEE_FF01);
    chk("s3_blk1", block_o, 64'h99AA_BBCC_DD00_0000);
    pop(1'b0, 1'b0);
    chk("s3_done_wready", {63'd0, wready_o}, 64'd0);

    // Backpressure: full block held for 10 cycles while words are offered
    load(16'd8, 16'd0);
    push(32'hCAFE_0001);
    push(32'hCAFE_0002);
    wdata_i  = 32'hDEAD_BEEF;
    wvalid_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    wvalid_i = 1'b0;
    chk("s4_wready", {63'd0, wready_o}, 64'd0);
    chk("s4_dv", {63'd0, data_valid_o}, 64'd1);
    chk("s4_block", block_o, 64'hCAFE_0001_CAFE_0002);
    pop(1'b1, 1'b0);

    // Abort after one word, then reload restarts at AD block 0
    load(16'd16, 16'd0);
    push(32'h0BAD_0BAD);
    idle_i = 1'b1;
    step();
    idle_i = 1'b0;
    chk("s5_wready", {63'd0, wready_o}, 64'd0);
    chk("s5_dv", {63'd0, data_valid_o}, 64'd0);
    load(16'd16, 16'd0);
    chk("s5_ad_last", {63'd0, ad_last_o}, 64'd0);
    push(32'h1234_5678);
    push(32'h9ABC_DEF0);
    chk("s5_block", block_o, 64'h1234_5678_9ABC_DEF0);

    // Empty AD and DI: straight to Done
    load(16'd0, 16'd0);
    step();
    chk("s6_wready", {63'd0, wready_o}, 64'd0);
    chk("s6_dv", {63'd0, data_valid_o}, 64'd0);

    // Async reset with a full block pending
    load(16'd8, 16'd8);
    push(32'hFFFF_0000);
    push(32'h0000_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_block", block_o, 64'd0);
    chk("s7_dv", {63'd0, data_valid_o}, 64'd0);
    chk("s7_wready", {63'd0, wready_o}, 64'd0);
    chk("s7_lasts", {62'd0, ad_last_o, di_last_o}, 64'd3);
    #3;
    rst_n = 1'b1;
    step();
    chk("s7_post_block", block_o, 64'd0);
    chk("s7_post_wready", {63'd0, wready_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
